// File: rtl/spi_txfifo_arbiter_pkg.sv
// Shared types and helpers for the SPI transmit FIFO write-side arbiter.
// Optional header tagging is enabled by defining SPI_TXARB_TAG_EN.
package spi_txarb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_HDR,
        ST_XFER,
        ST_DROP
    } state_t;

    // Header layout: length occupies the low LW bits, requester id sits right above it.
    localparam int HDR_LEN_LSB = 0;

    // Requester id width; a single bit is kept even for two requesters.
    function automatic int idw_of(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

    // Length/level width: one more bit than the FIFO address so DEPTH itself fits.
    function automatic int lw_of(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int hdr_id_lsb(input int lw);
        return lw;
    endfunction

    // Header word: {0..., id, len}; caller truncates to the FIFO word width.
    function automatic logic [63:0] build_hdr(input logic [31:0] len,
                                              input logic [31:0] id,
                                              input int          lw);
        return (64'(len) << HDR_LEN_LSB) | (64'(id) << hdr_id_lsb(lw));
    endfunction

endpackage

// File: rtl/spi_txfifo_arbiter_if.sv
// Requester and FIFO write-port signals of the SPI transmit FIFO arbiter.
// master: requesters plus FIFO status side; slave: the arbiter.
interface spi_txfifo_arbiter_if #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LW         = 5
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*LW-1:0]         req_len;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_dvalid;
    logic [NREQ-1:0]            req_dready;
    logic [NREQ-1:0]            req_grant;
    logic [NREQ-1:0]            req_done;
    logic                       fifo_wr_en;
    logic [DATA_WIDTH-1:0]      fifo_wr_data;
    logic                       fifo_wr_full;
    logic [LW-1:0]              fifo_wr_level;
    logic                       busy;
    logic                       err_len;

    modport master (
        output req_valid, req_len, req_data, req_dvalid, fifo_wr_full, fifo_wr_level,
        input  req_dready, req_grant, req_done, fifo_wr_en, fifo_wr_data, busy, err_len
    );

    modport slave (
        input  req_valid, req_len, req_data, req_dvalid, fifo_wr_full, fifo_wr_level,
        output req_dready, req_grant, req_done, fifo_wr_en, fifo_wr_data, busy, err_len
    );
endinterface

// File: rtl/spi_txfifo_arbiter_rr_arbiter.sv
// Rotating-priority picker: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);
    int idx;

    // Scan requesters in priority order starting from ptr and keep the first hit.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/spi_txfifo_arbiter.sv
// Packet-granular round-robin scheduler for the SPI transmit FIFO write port.
// Space for the whole packet is reserved before granting, so packets never
// interleave or stall mid-burst for lack of room.
// Define SPI_TXARB_TAG_EN to prefix each packet with a {id, len} header word.
module spi_txfifo_arbiter
    import spi_txarb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    spi_txfifo_arbiter_if.slave   bus
);
    localparam int LW  = lw_of(ADDR_WIDTH);
    localparam int IDW = idw_of(NREQ);

`ifdef SPI_TXARB_TAG_EN
    localparam int     TAG_W    = 1;
    localparam state_t FIRST_ST = ST_HDR;
`else
    localparam int     TAG_W    = 0;
    localparam state_t FIRST_ST = ST_XFER;
`endif

    state_t                state;
    logic [NREQ-1:0]       grant_q;
    logic [IDW-1:0]        gid_q;
    logic [IDW-1:0]        rr_ptr;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         cnt_q;
    logic [LW:0]           need_q;

    logic [NREQ-1:0]       arb_gnt;
    logic [IDW-1:0]        arb_id;
    logic                  arb_any;
    logic [LW-1:0]         win_len;
    logic [LW:0]           need_w;
    logic [LW-1:0]         free_w;
    logic                  win_bad;
    logic                  fits_w;
    logic                  fits_q;
    logic [IDW-1:0]        next_ptr;
    logic                  beat;
    logic                  last_beat;
    logic                  hdr_wr;
    logic [DATA_WIDTH-1:0] hdr_w;
    logic [DATA_WIDTH-1:0] pay_w;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr_arbiter (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // Space check; the level may lag reads, so free is never overestimated.
    assign win_len  = bus.req_len[arb_id*LW +: LW];
    assign need_w   = {1'b0, win_len} + (LW+1)'(TAG_W);
    assign free_w   = LW'(DEPTH) - bus.fifo_wr_level;
    assign win_bad  = (win_len == '0) || (need_w > (LW+1)'(DEPTH));
    assign fits_w   = {1'b0, free_w} >= need_w;
    assign fits_q   = {1'b0, free_w} >= need_q;
    assign next_ptr = (gid_q == IDW'(NREQ-1)) ? '0 : gid_q + 1'b1;

    // Write path is combinational so a beat lands in the FIFO the cycle it is offered.
    assign bus.req_dready = (state == ST_XFER && !bus.fifo_wr_full) ? grant_q : '0;
    assign beat           = |(bus.req_dready & bus.req_dvalid);
    assign last_beat      = beat && (cnt_q == len_q - 1'b1);
    assign hdr_wr         = (state == ST_HDR) && !bus.fifo_wr_full;
    assign hdr_w          = DATA_WIDTH'(build_hdr(32'(len_q), 32'(gid_q), LW));
    assign pay_w          = bus.req_data[gid_q*DATA_WIDTH +: DATA_WIDTH];

    assign bus.fifo_wr_en   = beat | hdr_wr;
    assign bus.fifo_wr_data = hdr_wr ? hdr_w : (beat ? pay_w : '0);
    assign bus.req_grant    = grant_q;
    assign bus.req_done     = ((state == ST_DROP) || last_beat) ? grant_q : '0;
    assign bus.err_len      = (state == ST_DROP);
    assign bus.busy         = (state != ST_IDLE);

    // Packet scheduler: arbitrate in IDLE, then own the write port until the packet ends.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            rr_ptr  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            need_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gid_q  <= arb_id;
                        len_q  <= win_len;
                        need_q <= need_w;
                        cnt_q  <= '0;
                        if (win_bad) begin
                            state   <= ST_DROP;
                            grant_q <= arb_gnt;
                        end else if (fits_w) begin
                            state   <= FIRST_ST;
                            grant_q <= arb_gnt;
                        end else begin
                            state   <= ST_WAIT_SPACE;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (fits_q) begin
                        state   <= FIRST_ST;
                        grant_q <= NREQ'(1) << gid_q;
                    end
                end
                ST_HDR: begin
                    if (!bus.fifo_wr_full) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (last_beat) begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                        rr_ptr  <= next_ptr;
                    end else if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DROP: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                    rr_ptr  <= next_ptr;
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txfifo_arbiter.sv
// Self-checking bench for spi_txfifo_arbiter: reset, table of arbitration
// decisions, directed multi-cycle sequences and a randomized run against a
// packet-level reference model. Honours SPI_TXARB_TAG_EN.
module tb_spi_txfifo_arbiter;
    localparam int NREQ  = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
`ifdef SPI_TXARB_TAG_EN
    localparam int TAG = 1;
`else
    localparam int TAG = 0;
`endif
    localparam int K_GRANT = 0;
    localparam int K_WAIT  = 1;
    localparam int K_DROP  = 2;

    typedef struct {
        int r;
        int len;
        int level;
        int kind;
    } vec_t;

    typedef struct {
        int          len;
        logic [31:0] base;
    } pkt_t;

    logic wr_clk   = 1'b0;
    logic wr_rst_n = 1'b0;
    int   total    = 0;
    int   bad      = 0;

    always #5 wr_clk = ~wr_clk;

    spi_txfifo_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .LW(LW)) bus ();

    spi_txfifo_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .wr_clk   (wr_clk),
        .wr_rst_n (wr_rst_n),
        .bus      (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input int len, input logic [31:0] data,
                           input logic v, input logic dv);
        bus.req_valid[i]          = v;
        bus.req_len[i*LW +: LW]   = LW'(len);
        bus.req_data[i*DW +: DW]  = data;
        bus.req_dvalid[i]         = dv;
    endtask

    task automatic idle_inputs();
        bus.req_valid     = '0;
        bus.req_len       = '0;
        bus.req_data      = '0;
        bus.req_dvalid    = '0;
        bus.fifo_wr_full  = 1'b0;
        bus.fifo_wr_level = '0;
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        wr_rst_n = 1'b0;
        idle_inputs();
        #1;
        wr_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[11];
        pkt_t        pq[NREQ][$];
        logic [31:0] got[$];
        int          bidx[NREQ];
        int          fcnt, mptr, expw, cyc, dv_div, g, idx;
        logic [NREQ-1:0] oh;
        logic        legal;
        logic [31:0] expword;

        tbl[0]  = '{0, 4,  0,  K_GRANT};
        tbl[1]  = '{1, 4,  12, (TAG != 0) ? K_WAIT : K_GRANT};
        tbl[2]  = '{1, 4,  13, K_WAIT};
        tbl[3]  = '{0, 16, 0,  (TAG != 0) ? K_DROP : K_GRANT};
        tbl[4]  = '{0, 16, 1,  (TAG != 0) ? K_DROP : K_WAIT};
        tbl[5]  = '{0, 0,  0,  K_DROP};
        tbl[6]  = '{1, 17, 0,  K_DROP};
        tbl[7]  = '{1, 1,  15, (TAG != 0) ? K_WAIT : K_GRANT};
        tbl[8]  = '{0, 1,  16, K_WAIT};
        tbl[9]  = '{1, 31, 0,  K_DROP};
        tbl[10] = '{1, 15, 0,  K_GRANT};

        // ---- reset holds every output low even with requests pending
        idle_inputs();
        wr_rst_n = 1'b0;
        set_req(0, 4, 32'h1111_1111, 1'b1, 1'b1);
        set_req(1, 4, 32'h2222_2222, 1'b1, 1'b1);
        repeat (3) @(posedge wr_clk);
        @(negedge wr_clk);
        check("rst_grant",  bus.req_grant,    0);
        check("rst_done",   bus.req_done,     0);
        check("rst_dready", bus.req_dready,   0);
        check("rst_wr_en",  bus.fifo_wr_en,   0);
        check("rst_wr_data",bus.fifo_wr_data, 0);
        check("rst_busy",   bus.busy,         0);
        check("rst_err",    bus.err_len,      0);

        // ---- table: one arbitration decision from IDLE per record
        for (int v = 0; v < 11; v++) begin
            do_reset();
            set_req(tbl[v].r, tbl[v].len, 32'h0, 1'b1, 1'b0);
            bus.fifo_wr_level = LW'(tbl[v].level);
            @(posedge wr_clk);
            #1;
            oh = NREQ'(1) << tbl[v].r;
            check("tbl_grant", bus.req_grant, (tbl[v].kind != K_WAIT) ? oh : '0);
            check("tbl_err",   bus.err_len,   (tbl[v].kind == K_DROP) ? 1 : 0);
            check("tbl_done",  bus.req_done,  (tbl[v].kind == K_DROP) ? oh : '0);
            check("tbl_busy",  bus.busy,      1);
        end

`ifndef SPI_TXARB_TAG_EN
        // ---- req0 len=4, empty FIFO
        do_reset();
        @(negedge wr_clk);
        set_req(0, 4, 32'hA0, 1'b1, 1'b0);
        #1;
        check("s1_grant_pre", bus.req_grant, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge wr_clk);
            set_req(0, 4, 32'hA0 + 32'(k), 1'b1, 1'b1);
            #1;
            if (k == 0) check("s1_grant", bus.req_grant, 2'b01);
            check("s1_wr_en", bus.fifo_wr_en,   1);
            check("s1_data",  bus.fifo_wr_data, 32'hA0 + 32'(k));
            check("s1_done",  bus.req_done,     (k == 3) ? 2'b01 : 2'b00);
        end
        @(negedge wr_clk);
        set_req(0, 0, 32'h0, 1'b0, 1'b0);
        #1;
        check("s1_idle", bus.busy, 0);

        // ---- both requesters len=3, always requesting: 0,1,0,1 with one idle cycle between
        do_reset();
        @(negedge wr_clk);
        set_req(0, 3, 32'hB000_0000, 1'b1, 1'b1);
        set_req(1, 3, 32'hB000_0001, 1'b1, 1'b1);
        for (int c = 0; c < 17; c++) begin
            if (c > 0) @(negedge wr_clk);
            #1;
            oh = ((c % 4) == 0) ? 2'b00 : (NREQ'(1) << ((c / 4) % 2));
            check("s2_grant", bus.req_grant,  oh);
            check("s2_wr_en", bus.fifo_wr_en, ((c % 4) != 0) ? 1 : 0);
            check("s2_done",  bus.req_done,   ((c % 4) == 3) ? oh : 2'b00);
            if ((c % 4) != 0)
                check("s2_data", bus.fifo_wr_data, 32'hB000_0000 + 32'((c / 4) % 2));
        end

        // ---- insufficient space: req1 waits, req0 arriving meanwhile is not served first
        do_reset();
        @(negedge wr_clk);
        bus.fifo_wr_level = LW'(14);
        set_req(1, 4, 32'hC0, 1'b1, 1'b0);
        #1;
        check("s3_busy_pre", bus.busy, 0);
        @(negedge wr_clk);
        #1;
        check("s3_busy_wait", bus.busy, 1);
        check("s3_no_grant",  bus.req_grant, 0);
        set_req(0, 2, 32'hD0, 1'b1, 1'b0);
        @(negedge wr_clk);
        #1;
        check("s3_still_wait", bus.req_grant, 0);
        bus.fifo_wr_level = LW'(12);
        @(negedge wr_clk);
        #1;
        check("s3_grant1", bus.req_grant, 2'b10);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge wr_clk);
            set_req(1, 4, 32'hC0 + 32'(k), 1'b1, 1'b1);
            #1;
            check("s3_data", bus.fifo_wr_data, 32'hC0 + 32'(k));
            check("s3_done", bus.req_done, (k == 3) ? 2'b10 : 2'b00);
        end
        @(negedge wr_clk);
        set_req(1, 0, 32'h0, 1'b0, 1'b0);
        #1;
        check("s3_gap", bus.req_grant, 0);
        @(negedge wr_clk);
        #1;
        check("s3_then_req0", bus.req_grant, 2'b01);

        // ---- reset in the middle of a packet
        do_reset();
        @(negedge wr_clk);
        set_req(0, 4, 32'hE0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge wr_clk);
            set_req(0, 4, 32'hE0 + 32'(k), 1'b1, 1'b1);
            #1;
            check("s4_beat", bus.fifo_wr_en, 1);
        end
        @(negedge wr_clk);
        wr_rst_n = 1'b0;
        #1;
        check("s4_rst_wr_en",  bus.fifo_wr_en,  0);
        check("s4_rst_grant",  bus.req_grant,   0);
        check("s4_rst_busy",   bus.busy,        0);
        check("s4_rst_dready", bus.req_dready,  0);
        for (int k = 0; k < 2; k++) begin
            @(negedge wr_clk);
            #1;
            check("s4_held_wr_en", bus.fifo_wr_en, 0);
        end
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        set_req(0, 2, 32'hF0, 1'b1, 1'b0);
        @(negedge wr_clk);
        #1;
        check("s4_regrant", bus.req_grant, 2'b01);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge wr_clk);
            set_req(0, 2, 32'hF0 + 32'(k), 1'b1, 1'b1);
            #1;
            check("s4_data", bus.fifo_wr_data, 32'hF0 + 32'(k));
            check("s4_done", bus.req_done, (k == 1) ? 2'b01 : 2'b00);
        end
`else
        // ---- tagged packet: header word then payload; level 12 is not enough for len 4
        do_reset();
        @(negedge wr_clk);
        bus.fifo_wr_level = LW'(12);
        set_req(1, 4, 32'h100, 1'b1, 1'b0);
        @(negedge wr_clk);
        #1;
        check("t_wait_busy",  bus.busy, 1);
        check("t_wait_grant", bus.req_grant, 0);
        bus.fifo_wr_level = LW'(11);
        @(negedge wr_clk);
        #1;
        check("t_grant", bus.req_grant, 2'b10);
        check("t_hdr_en", bus.fifo_wr_en, 1);
        check("t_hdr", bus.fifo_wr_data, 32'h0000_0024);
        for (int k = 0; k < 4; k++) begin
            @(negedge wr_clk);
            set_req(1, 4, 32'h100 + 32'(k), 1'b1, 1'b1);
            #1;
            check("t_data", bus.fifo_wr_data, 32'h100 + 32'(k));
            check("t_done", bus.req_done, (k == 3) ? 2'b10 : 2'b00);
        end
`endif

        // ---- randomized traffic against a packet-level model
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bidx[i] = 0;
            for (int n = 0; n < 40; n++) begin
                pkt_t p;
                int   r;
                r = int'($urandom_range(0, 9));
                if (r == 0)      p.len = 0;
                else if (r == 1) p.len = int'($urandom_range(DEPTH + 1, 31));
                else             p.len = int'($urandom_range(1, DEPTH));
                p.base = $urandom;
                pq[i].push_back(p);
            end
        end
        fcnt   = 0;
        mptr   = 0;
        expw   = -1;
        cyc    = 0;
        dv_div = 2;
        while ((pq[0].size() > 0 || pq[1].size() > 0) && cyc < 20000) begin
            @(negedge wr_clk);
            cyc++;
            if ((cyc % 64) == 0) dv_div = int'($urandom_range(1, 5));
            for (int i = 0; i < NREQ; i++) begin
                if (pq[i].size() > 0)
                    set_req(i, pq[i][0].len, pq[i][0].base + 32'(bidx[i]), 1'b1,
                            ($urandom_range(0, 3) != 0));
                else
                    set_req(i, 0, 32'h0, 1'b0, 1'b0);
            end
            bus.fifo_wr_level = LW'(fcnt);
            bus.fifo_wr_full  = (fcnt == DEPTH);
            #1;
            if (!bus.busy && bus.req_valid != '0) begin
                expw = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    if (expw < 0 && bus.req_valid[idx]) expw = idx;
                end
            end
            if (bus.fifo_wr_en) begin
                if (fcnt >= DEPTH) check("r_overflow", fcnt, DEPTH - 1);
                got.push_back(bus.fifo_wr_data);
                fcnt++;
            end
            for (int i = 0; i < NREQ; i++)
                if (bus.req_dready[i] && bus.req_dvalid[i]) bidx[i]++;
            if (bus.req_done != '0) begin
                g = 0;
                for (int i = NREQ - 1; i >= 0; i--) if (bus.req_done[i]) g = i;
                check("r_done_onehot", $countones(bus.req_done), 1);
                check("r_rr_order", g, expw);
                legal = (pq[g][0].len >= 1) && (pq[g][0].len + TAG <= DEPTH);
                check("r_err_len", bus.err_len, !legal);
                if (legal) begin
                    check("r_pkt_len", got.size(), pq[g][0].len + TAG);
                    if (got.size() == pq[g][0].len + TAG) begin
                        for (int k = 0; k < got.size(); k++) begin
                            if (TAG != 0 && k == 0)
                                expword = (32'(g) << LW) | 32'(pq[g][0].len);
                            else
                                expword = pq[g][0].base + 32'(k - TAG);
                            check("r_pkt_word", got[k], expword);
                        end
                    end
                end else begin
                    check("r_drop_nowrite", got.size(), 0);
                end
                void'(pq[g].pop_front());
                bidx[g] = 0;
                got.delete();
                mptr = (g + 1) % NREQ;
                expw = -1;
            end
            if (fcnt > 0 && $urandom_range(1, dv_div) == 1) fcnt--;
        end
        check("r_all_served", pq[0].size() + pq[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_txfifo_arbiter.md
# spi_txfifo_arbiter

Write-side scheduler for the AXI4-to-SPI transmit async FIFO. Shares the FIFO's write port between NREQ requesters (e.g. AXI write-data path, register/command engine) at packet granularity. Round-robin arbitration; reserves FIFO space for a whole packet before granting, so packets are never interleaved or stalled mid-burst. Runs entirely in the FIFO's write clock domain.

## Interface
- NREQ, 2, number of requesters (≥2)
- DATA_WIDTH, 32, FIFO word width
- DEPTH, 16, FIFO depth in words (power of two)
- ADDR_WIDTH, $clog2(DEPTH), FIFO address width; LW = ADDR_WIDTH+1 is the length/level width
- wr_clk  in  1  write-domain clock
- wr_rst_n  in  1  reset wr_rst_n, asynchronous, active-low; clock wr_clk
- req_valid  in  NREQ  requester i has a packet pending
- req_len  in  NREQ*LW  packet length in words, slice i, legal 1..DEPTH
- req_data  in  NREQ*DATA_WIDTH  data beat, slice i
- req_dvalid  in  NREQ  data beat valid
- req_dready  out  NREQ  beat accepted (grant & XFER & !fifo_wr_full)
- req_grant  out  NREQ  one-hot, held for the whole packet
- req_done  out  NREQ  one-hot 1-cycle pulse on packet end
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
- fifo_wr_full  in  1  from FIFO wr_full
- fifo_wr_level  in  LW  from FIFO wr_level
- busy  out  1  state != IDLE
- err_len  out  1  1-cycle pulse: illegal length dropped

## Operation
- States: IDLE, WAIT_SPACE, HDR (macro only), XFER, DROP.
- IDLE: if any req_valid, the winner is the first set bit starting at rr_ptr. need = req_len, plus 1 with tag. Illegal (len==0 or need>DEPTH) -> DROP. Else if DEPTH - fifo_wr_level ≥ need -> XFER (or HDR). Else -> WAIT_SPACE.
- WAIT_SPACE: winner latched; no re-arbitration, even if another requester fits. Leave when space ≥ need.
- Winner id and len are latched on leaving IDLE. req_valid changes after that are ignored until req_done.
- XFER: beat = req_dvalid[g] & req_dready[g]. fifo_wr_en = beat and fifo_wr_data = req_data[g]. Both are combinational (zero latency). A beat counter counts up to len.
- Last beat: req_done[g] pulses in the same cycle. Next state IDLE; rr_ptr = g+1 mod NREQ.
- DROP: one cycle. req_grant[g], req_done[g] and err_len are all asserted. No FIFO write. rr_ptr advances. Next state IDLE.
- fifo_wr_full is always honoured: req_dready is gated by it. fifo_wr_level is conservative because the read pointer is synchronized, so the space check never overestimates.
- Arithmetic: free = DEPTH - fifo_wr_level in LW bits; a level of DEPTH gives free = 0.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr 0, counters 0. Reset mid-packet aborts immediately. No further writes occur; the partial packet stays in the FIFO.
- req_valid sampled in IDLE -> req_grant registered 1 cycle later (space available).
- Back-to-back packets: one IDLE cycle between req_done and the next grant.
- Throughput: 1 word/cycle in XFER while req_dvalid is high.

## Configuration
- SPI_TXARB_TAG_EN defined:
  - HDR state writes one header word before the payload: bits [LW-1:0] = len, bits [LW+IDW-1:LW] = requester id (IDW = max(1,$clog2(NREQ))), all other bits 0.
  - need = len+1.
  - HDR stalls while fifo_wr_full is high.
- SPI_TXARB_TAG_EN undefined: no HDR state; payload only; need = len.

## Structure
- Package spi_txarb_pkg holds:
  - state enum
  - IDW/LW width constants
  - header field offsets
  - header-build function
- Sub-module rr_arbiter: rotating-priority one-hot picker taking req_valid and rr_ptr; purely combinational.

## Test plan
- Reset: hold wr_rst_n=0 and drive req_valid=2'b11 -> all outputs 0, busy=0.
- req0 len=4, data 0xA0..0xA3, FIFO empty:
  - grant[0] asserts 1 cycle after req_valid.
  - 4 fifo_wr_en beats in order; req_done[0] on the 4th beat.
- Both requesters len=3, continuously re-requesting:
  - packets are granted 0,1,0,1, with no interleaved words.
  - exactly 1 idle cycle between packets.
- fifo_wr_level=14, req1 len=4:
  - WAIT_SPACE, busy=1, no grant.
  - when level drops to 12, grant[1] asserts the next cycle.
  - req0 arriving meanwhile is not served first.
- req0 len=0, then req1 len=17:
  - each gives a 1-cycle grant + req_done + err_len.
  - fifo_wr_en never asserts.
- Assert wr_rst_n low after 2 of 4 beats -> outputs 0 immediately, no more writes; after release, req0 len=2 completes normally.
- With SPI_TXARB_TAG_EN, req1 len=4:
  - first word is 0x0000_0024 (id=1 at bit 5, len=4), followed by 4 payload words.
  - at level 12, the request waits until level ≤ 11.
